inst_queue: RTL
===============

Name: inst_queue

Overview:
- Dual-ported instruction queue between the fetch stage and id_stage.
- Accepts 0, 1 or 2 fetched instruction packets per cycle from IF.
- Presents the two oldest entries to decode as fifo_to_ds_valid_0/1 and fifo_to_ds_bus_0/1.
- Retires 0, 1 or 2 entries per cycle according to the issue_mode returned by id_stage; flushed on redirect.

Parameters:
DEPTH, 16, number of entries; power of two, at least 4
BUS_WD, `FIFO_TO_DS_BUS_WD, width of one instruction packet

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
flush  input  1  discard all entries (branch redirect / exception / eret)
fs_to_fifo_valid_0  input  1  IF packet 0 valid (older)
fs_to_fifo_valid_1  input  1  IF packet 1 valid (younger)
fs_to_fifo_bus_0  input  BUS_WD  IF packet 0
fs_to_fifo_bus_1  input  BUS_WD  IF packet 1
fifo_allowin  output  1  queue can take two packets this cycle
issue_mode  input  2  from id_stage: 0 none, `SIGNLE (2'b01) pop 1, `DUAL (2'b10) pop 2
fifo_to_ds_valid_0  output  1  head entry valid
fifo_to_ds_valid_1  output  1  head+1 entry valid
fifo_to_ds_bus_0  output  BUS_WD  head entry
fifo_to_ds_bus_1  output  BUS_WD  head+1 entry
fifo_count  output  log2(DEPTH)+1  occupied entries (perf/debug)

Behaviour:
- Reset is synchronous and active-high: head=0, tail=0, count=0. fifo_allowin=1; both valids=0.
- Storage: circular array of DEPTH entries. head/tail pointers wrap modulo DEPTH; separate count register.
- fifo_allowin = (DEPTH - count >= 2), computed from registered count only (no combinational path from issue_mode).
- Write with fifo_allowin=1:
  - valid_0 & valid_1: bus_0 written at tail, bus_1 at tail+1; tail += 2.
  - valid_0 only: bus_0 written at tail; tail += 1.
  - valid_1 without valid_0: ignored, nothing written.
- Writes while fifo_allowin=0 are dropped. IF must hold its packets.
- Read outputs are combinational from registered state:
  - valid_0 = count>=1; valid_1 = count>=2.
  - bus_0 = mem[head]; bus_1 = mem[head+1 mod DEPTH].
- Invalid output buses carry stale data, don't-care.
- Pop amount:
  - `DUAL pops min(2,count).
  - `SIGNLE pops min(1,count).
  - 0 or 2'b11 pops 0.
- Pop and head advance take effect at the clock edge.
- Same-cycle push and pop: count_next = count + pushed - popped. An entry written this cycle is not visible to decode until the next cycle (no bypass).
- Latency: a packet written at edge N appears on fifo_to_ds_bus_0 after edge N if the queue was empty.
- Order: strict program order; packet 0 is older than packet 1; wrap-around is seamless (bus_1 may come from index 0 while bus_0 is at DEPTH-1).
- flush: at the clock edge, head=tail=0 and count=0. Same-cycle writes and pops are discarded; flush has priority. Valids are 0 on the following cycle.
- reset has priority over flush.

Test Plan:
- Reset, then no stimulus -> valids 0, fifo_count 0, fifo_allowin 1.
- Push pairs A,B then C,D with issue_mode 0 -> count 4; bus_0=A, bus_1=B. Then `SIGNLE -> bus_0=B, bus_1=C, count 3.
- DEPTH=16: push 8 pairs -> count 16, fifo_allowin 0. Further valid push ignored, count stays 16. Then `DUAL -> count 14, allowin 1.
- Wrap: 15 singles popped/pushed so head=15, count 2 -> bus_0=mem[15], bus_1=mem[0]; `DUAL -> count 0.
- Same cycle: count 1, push pair, `DUAL -> count_next 2 (pop clipped to 1); new head = first pushed packet.
- Flush with simultaneous push pair and `SIGNLE at count 5 -> next cycle count 0, valids 0. Next push appears at bus_0 one cycle later.

Source files
------------

// File: rtl/inst_queue.sv
// inst_queue: dual-ported circular instruction queue between fetch and decode.
`ifndef FIFO_TO_DS_BUS_WD
`define FIFO_TO_DS_BUS_WD 32
`endif
module inst_queue #(
   parameter int DEPTH  = 16,
   parameter int BUS_WD = `FIFO_TO_DS_BUS_WD
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       fs_to_fifo_valid_0,
   input  logic                       fs_to_fifo_valid_1,
   input  logic [BUS_WD-1:0]          fs_to_fifo_bus_0,
   input  logic [BUS_WD-1:0]          fs_to_fifo_bus_1,
   output logic                       fifo_allowin,
   input  logic [1:0]                 issue_mode,
   output logic                       fifo_to_ds_valid_0,
   output logic                       fifo_to_ds_valid_1,
   output logic [BUS_WD-1:0]          fifo_to_ds_bus_0,
   output logic [BUS_WD-1:0]          fifo_to_ds_bus_1,
   output logic [$clog2(DEPTH):0]     fifo_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [1:0] SIGNLE = 2'b01;
   localparam logic [1:0] DUAL   = 2'b10;
   logic [BUS_WD-1:0] mem [DEPTH];
   logic [AW-1:0]     head, tail;
   logic [AW:0]       count;
   logic [1:0]        push, pop;
   always_comb begin
      fifo_allowin       = count <= (AW+1)'(DEPTH - 2);
      push               = !fifo_allowin || !fs_to_fifo_valid_0 ? 2'd0 : fs_to_fifo_valid_1 ? 2'd2 : 2'd1;
      pop                = issue_mode == DUAL && count >= 2 ? 2'd2 :
                           (issue_mode == DUAL || issue_mode == SIGNLE) && count != 0 ? 2'd1 : 2'd0;
      fifo_to_ds_valid_0 = count != 0;
      fifo_to_ds_valid_1 = count >= 2;
      fifo_to_ds_bus_0   = mem[head];
      fifo_to_ds_bus_1   = mem[head + AW'(1)];
      fifo_count         = count;
   end
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(pop);
         tail  <= tail + AW'(push);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   // Storage needs no reset; entries are only observed while counted as valid.
   always_ff @(posedge clk) begin
      if (!reset && !flush && push != 2'd0) mem[tail] <= fs_to_fifo_bus_0;
      if (!reset && !flush && push == 2'd2) mem[tail + AW'(1)] <= fs_to_fifo_bus_1;
   end
endmodule
